// File: rtl/int_divider_if.sv
// Divider <-> EXE-stage bundle: operands and control from the pipeline,
// stall/done/result back to it.
interface int_divider_if #(
    parameter int XLEN = 32
);
    logic            div_start;
    logic [1:0]      div_op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            flush;
    logic            pipe_advance;
    logic            divide_stall;
    logic            div_done;
    logic [XLEN-1:0] div_result;

    modport master (
        output div_start, div_op, dividend, divisor, flush, pipe_advance,
        input  divide_stall, div_done, div_result
    );

    modport slave (
        input  div_start, div_op, dividend, divisor, flush, pipe_advance,
        output divide_stall, div_done, div_result
    );
endinterface

// File: rtl/int_divider.sv
// Multi-cycle RV32M restoring divider (DIV/DIVU/REM/REMU) that freezes the
// pipeline while iterating; divide-by-zero and signed overflow finish at issue.
module int_divider #(
    parameter int XLEN = 32
) (
    input logic          clk,
    input logic          reset,
    int_divider_if.slave dif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0]      LAST_CNT = 6'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [5:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvsr_q, dvsr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            is_rem_q, is_rem_d;

    logic            op_signed, op_rem;
    logic            dvd_neg, dvs_neg;
    logic            div_by_zero, overflow, special;
    logic            special_now, start_now;
    logic [XLEN-1:0] dvd_mag, dvs_mag, special_result;
    logic [XLEN:0]   trial;
    logic [XLEN-1:0] rem_step, quo_step, rem_fixed, quo_fixed;

    // Operand decode and the two cases that resolve without iterating
    always_comb begin
        op_signed   = ~dif.div_op[0];
        op_rem      = dif.div_op[1];
        dvd_neg     = op_signed & dif.dividend[XLEN-1];
        dvs_neg     = op_signed & dif.divisor[XLEN-1];
        dvd_mag     = dvd_neg ? -dif.dividend : dif.dividend;
        dvs_mag     = dvs_neg ? -dif.divisor : dif.divisor;
        div_by_zero = (dif.divisor == '0);
        overflow    = op_signed & (dif.dividend == MIN_INT) & (dif.divisor == '1);
        special     = div_by_zero | overflow;
        if (div_by_zero) begin
            special_result = op_rem ? dif.dividend : '1;
        end else begin
            special_result = op_rem ? '0 : MIN_INT;
        end
        special_now = (state_q == IDLE) & dif.div_start & special & ~dif.flush;
        start_now   = (state_q == IDLE) & dif.div_start & ~special & ~dif.flush;
    end

    // One restoring step: shift {rem, quo} left, trial-subtract in XLEN+1 bits
    always_comb begin
        trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvsr_q};
        if (trial[XLEN]) begin
            rem_step = {rem_q[XLEN-2:0], quo_q[XLEN-1]};
            quo_step = {quo_q[XLEN-2:0], 1'b0};
        end else begin
            rem_step = trial[XLEN-1:0];
            quo_step = {quo_q[XLEN-2:0], 1'b1};
        end
        quo_fixed = q_neg_q ? -quo_step : quo_step;
        rem_fixed = r_neg_q ? -rem_step : rem_step;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            result_q <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            is_rem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            result_q <= result_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            is_rem_q <= is_rem_d;
        end
    end

    // Next state: flush wins everywhere; DONE ignores div_start (same instruction)
    always_comb begin
        state_d = state_q;
        if (dif.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (dif.div_start && !special) state_d = BUSY;
                BUSY:    if (cnt_q == LAST_CNT) state_d = DONE;
                DONE:    if (dif.pipe_advance) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        result_d = result_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        is_rem_d = is_rem_q;
        if (dif.flush) begin
            cnt_d = '0;
        end else if (start_now) begin
            cnt_d    = '0;
            rem_d    = '0;
            quo_d    = dvd_mag;
            dvsr_d   = dvs_mag;
            q_neg_d  = dvd_neg ^ dvs_neg;
            r_neg_d  = dvd_neg;
            is_rem_d = op_rem;
        end else if (state_q == BUSY) begin
            cnt_d = cnt_q + 6'd1;
            rem_d = rem_step;
            quo_d = quo_step;
            if (cnt_q == LAST_CNT) begin
                result_d = is_rem_q ? rem_fixed : quo_fixed;
            end
        end
    end

    // Outputs: the only operand-to-result path is the special-case bypass
    always_comb begin
        dif.divide_stall = ~dif.flush & (start_now | (state_q == BUSY));
        dif.div_done     = special_now | ((state_q == DONE) & ~dif.flush);
        dif.div_result   = special_now ? special_result : result_q;
    end
endmodule

// File: tb/tb_int_divider.sv
// Directed bench for int_divider: timing, signed/unsigned results, special
// cases, flush, DONE hold, back-to-back issue and asynchronous reset.
module tb_int_divider;
    localparam int XLEN = 32;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   cyc;

    int_divider_if #(.XLEN(XLEN)) dif ();

    int_divider #(.XLEN(XLEN)) u_dut (
        .clk   (clk),
        .reset (reset),
        .dif   (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        dif.div_start = 1'b1;
        dif.div_op    = op;
        dif.dividend  = a;
        dif.divisor   = b;
    endtask

    // Returns at the negedge of the cycle where div_done is seen
    task automatic wait_done(output int stalls, output bit seen);
        stalls = 0;
        seen   = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (dif.divide_stall) stalls++;
            if (dif.div_done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_div(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int stalls;
        bit seen;
        issue(op, a, b);
        wait_done(stalls, seen);
        check_val({tag, "_seen"}, 32'(seen), 32'd1);
        check_val({tag, "_stall"}, 32'(stalls), 32'd33);
        check_val({tag, "_res"}, dif.div_result, exp);
        $display("div %s op=%0d a=0x%08h b=0x%08h result=0x%08h stalls=%0d",
                 tag, op, a, b, dif.div_result, stalls);
        @(posedge clk); #1;
        dif.div_start = 1'b0;
    endtask

    task automatic do_special(input string tag, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
        issue(op, a, b);
        @(negedge clk);
        check_val({tag, "_done"}, 32'(dif.div_done), 32'd1);
        check_val({tag, "_stall"}, 32'(dif.divide_stall), 32'd0);
        check_val({tag, "_res"}, dif.div_result, exp);
        $display("special %s op=%0d a=0x%08h b=0x%08h result=0x%08h",
                 tag, op, a, b, dif.div_result);
        @(posedge clk); #1;
        dif.div_start = 1'b0;
        @(negedge clk);
        check_val({tag, "_idle"}, 32'(dif.div_done), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        int  stalls;
        bit  seen;
        int  c1;
        int  c2;
        logic [31:0] held;

        total = 0;
        bad   = 0;
        reset = 1'b1;
        dif.div_start    = 1'b0;
        dif.div_op       = 2'b00;
        dif.dividend     = '0;
        dif.divisor      = '0;
        dif.flush        = 1'b0;
        dif.pipe_advance = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_stall", 32'(dif.divide_stall), 32'd0);
        check_val("rst_done", 32'(dif.div_done), 32'd0);
        check_val("rst_res", dif.div_result, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        do_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);
        do_div("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2);
        do_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        do_div("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        do_div("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
        do_div("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF);

        do_special("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        do_special("rem_5_0", OP_REM, 32'd5, 32'd0, 32'd5);
        do_special("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        do_special("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Flush in BUSY cycle 10
        issue(OP_DIVU, 32'd1000, 32'd3);
        repeat (10) @(posedge clk);
        #1;
        dif.flush = 1'b1;
        @(negedge clk);
        check_val("flush_stall", 32'(dif.divide_stall), 32'd0);
        @(posedge clk); #1;
        dif.flush     = 1'b0;
        dif.div_start = 1'b0;
        @(negedge clk);
        check_val("flush_idle_stall", 32'(dif.divide_stall), 32'd0);
        check_val("flush_idle_done", 32'(dif.div_done), 32'd0);
        $display("flush at busy cycle 10 stall=%0d", dif.divide_stall);
        @(posedge clk); #1;
        do_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3);

        // DONE held for 3 cycles with pipe_advance low
        dif.pipe_advance = 1'b0;
        issue(OP_DIVU, 32'd100, 32'd7);
        wait_done(stalls, seen);
        check_val("hold_seen", 32'(seen), 32'd1);
        check_val("hold_res0", dif.div_result, 32'd14);
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 3) dif.pipe_advance = 1'b1;
            @(negedge clk);
            check_val($sformatf("hold_done%0d", k), 32'(dif.div_done), 32'd1);
            check_val($sformatf("hold_res%0d", k), dif.div_result, 32'd14);
            check_val($sformatf("hold_stall%0d", k), 32'(dif.divide_stall), 32'd0);
        end
        $display("hold done result=0x%08h", dif.div_result);
        @(posedge clk); #1;
        dif.div_start = 1'b0;
        @(negedge clk);
        check_val("hold_idle", 32'(dif.div_done), 32'd0);
        @(posedge clk); #1;

        // Back-to-back: second issue in the cycle right after DONE
        issue(OP_DIVU, 32'd100, 32'd10);
        wait_done(stalls, seen);
        c1 = cyc;
        check_val("b2b1_seen", 32'(seen), 32'd1);
        check_val("b2b1_res", dif.div_result, 32'd10);
        $display("b2b first result=0x%08h", dif.div_result);
        @(posedge clk); #1;
        issue(OP_DIVU, 32'd81, 32'd9);
        wait_done(stalls, seen);
        c2 = cyc;
        check_val("b2b2_seen", 32'(seen), 32'd1);
        check_val("b2b2_stall", 32'(stalls), 32'd33);
        check_val("b2b2_res", dif.div_result, 32'd9);
        check_val("b2b_spacing", 32'(c2 - c1), 32'd34);
        $display("b2b second result=0x%08h spacing=%0d", dif.div_result, c2 - c1);
        @(posedge clk); #1;
        dif.div_start = 1'b0;

        // Asynchronous reset in BUSY cycle 5
        @(posedge clk); #1;
        issue(OP_DIVU, 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        check_val("pre_rst_stall", 32'(dif.divide_stall), 32'd1);
        #2;
        reset         = 1'b1;
        dif.div_start = 1'b0;
        #1;
        check_val("arst_stall", 32'(dif.divide_stall), 32'd0);
        check_val("arst_done", 32'(dif.div_done), 32'd0);
        check_val("arst_res", dif.div_result, 32'd0);
        $display("async reset result=0x%08h", dif.div_result);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_div("post_rst", OP_DIVU, 32'd1000, 32'd7, 32'd142);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
